// File: rtl/board_cell_writer_pkg.sv
// board_cell_writer_pkg
//   Shared board geometry, cell coordinate type and the cell-edit opcode.
//   Imported by the writer, its interface, and the cell_addr_map helper
//   (which the renderer fetch stage uses as well).
package board_cell_writer_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int LOG_WORD_SIZE  = 4;
   localparam int BOARD_SIZE     = 64;
   localparam int LOG_BOARD_SIZE = 6;
   localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
   localparam int NUM_WORDS      = BOARD_SIZE * WORDS_PER_ROW;
   localparam int LOG_MAX_ADDR   = $clog2(NUM_WORDS);

   typedef logic [LOG_BOARD_SIZE-1:0] pos_t;

   typedef enum logic [1:0] {
      OP_SET       = 2'd0,
      OP_CLEAR     = 2'd1,
      OP_TOGGLE    = 2'd2,
      OP_CLEAR_ALL = 2'd3
   } cell_op_t;

endpackage

// File: rtl/board_cell_writer_if.sv
// board_cell_writer_if
//   Command channel plus board-memory port of the cell writer.
//   cmd_*     : valid/ready edit command (op, x, y)
//   mem_*     : grant, word address, read data, write data, write enable
//   status    : busy_out, done_out
//   modport slave  - the writer
//   modport master - command source / memory side
interface board_cell_writer_if;
   import board_cell_writer_pkg::*;

   logic                    cmd_valid_in;
   logic                    cmd_ready_out;
   cell_op_t                cmd_op_in;
   pos_t                    cmd_x_in;
   pos_t                    cmd_y_in;
   logic                    mem_grant_in;
   logic [LOG_MAX_ADDR-1:0] addr_out;
   logic [WORD_SIZE-1:0]    data_r_in;
   logic [WORD_SIZE-1:0]    data_w_out;
   logic                    we_out;
   logic                    busy_out;
   logic                    done_out;

   modport slave (
      input  cmd_valid_in, cmd_op_in, cmd_x_in, cmd_y_in, mem_grant_in, data_r_in,
      output cmd_ready_out, addr_out, data_w_out, we_out, busy_out, done_out
   );

   modport master (
      output cmd_valid_in, cmd_op_in, cmd_x_in, cmd_y_in, mem_grant_in, data_r_in,
      input  cmd_ready_out, addr_out, data_w_out, we_out, busy_out, done_out
   );

endinterface

// File: rtl/board_cell_writer_cell_addr_map.sv
// cell_addr_map
//   Combinational board-cell to memory-word mapping, shared with the renderer
//   so both ends agree on layout. MSB of a word is the leftmost cell.
//   x, y    : board coordinates
//   addr    : word address = y*WORDS_PER_ROW + (x >> LOG_WORD_SIZE)
//   bit_idx : WORD_SIZE-1 - x[LOG_WORD_SIZE-1:0]
module cell_addr_map
   import board_cell_writer_pkg::*;
(
   input  pos_t                     x,
   input  pos_t                     y,
   output logic [LOG_MAX_ADDR-1:0]  addr,
   output logic [LOG_WORD_SIZE-1:0] bit_idx
);

   assign addr    = LOG_MAX_ADDR'(y) * LOG_MAX_ADDR'(WORDS_PER_ROW)
                  + LOG_MAX_ADDR'(x >> LOG_WORD_SIZE);
   assign bit_idx = LOG_WORD_SIZE'(WORD_SIZE - 1) - x[LOG_WORD_SIZE-1:0];

endmodule

// File: rtl/board_cell_writer.sv
// board_cell_writer
//   Applies SET/CLEAR/TOGGLE edits to one board cell by read-modify-write of
//   the word-packed board memory, touching the port only while mem_grant_in=1.
//   Ports: clk_130mhz (posedge), rst_in (async, active high),
//          bus (board_cell_writer_if.slave: command channel + memory port).
//   Parameter: READ_LATENCY (1..4) cycles from addr_out to valid data_r_in.
//   Build option: CELL_WRITER_CLEAR_ALL_EN - op 3 zeroes every word, one per
//   granted cycle; without it op 3 just completes with no memory access.
module board_cell_writer
   import board_cell_writer_pkg::*;
#(
   parameter int READ_LATENCY = 2
) (
   input logic                clk_130mhz,
   input logic                rst_in,
   board_cell_writer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WAIT_GRANT, READ, WRITE, DONE, CLEAR} state_t;

   // READ spends one cycle presenting the address, then READ_LATENCY cycles
   // waiting; data is captured when rd_cnt reaches RD_LAST.
   localparam logic [2:0] RD_LAST = 3'(READ_LATENCY);
`ifdef CELL_WRITER_CLEAR_ALL_EN
   localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(NUM_WORDS - 1);
`endif

   state_t                   state, state_nxt;
   pos_t                     x_q, y_q;
   cell_op_t                 op_q;
   logic [2:0]               rd_cnt;
   logic [LOG_MAX_ADDR-1:0]  addr_q, map_addr;
   logic [LOG_WORD_SIZE-1:0] map_bit;
   logic [WORD_SIZE-1:0]     wdata_q, mask, word_mod;
   logic                     accept;

   assign accept = (state == IDLE) && bus.cmd_valid_in;

   cell_addr_map u_map (.x(x_q), .y(y_q), .addr(map_addr), .bit_idx(map_bit));

   always_comb begin
      mask = WORD_SIZE'(1) << map_bit;
      case (op_q)
         OP_SET:    word_mod = bus.data_r_in | mask;
         OP_CLEAR:  word_mod = bus.data_r_in & ~mask;
         OP_TOGGLE: word_mod = bus.data_r_in ^ mask;
         default:   word_mod = bus.data_r_in;
      endcase
   end

   // state register
   always_ff @(posedge clk_130mhz or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (accept) state_nxt = (bus.cmd_op_in == OP_CLEAR_ALL) ? CLEAR : WAIT_GRANT;
         WAIT_GRANT:
            if (bus.mem_grant_in) state_nxt = READ;
         READ:
            // losing the port mid-read invalidates the pipeline: start over
            if (!bus.mem_grant_in)    state_nxt = WAIT_GRANT;
            else if (rd_cnt == RD_LAST) state_nxt = WRITE;
         WRITE:
            if (bus.mem_grant_in) state_nxt = DONE;
         DONE:
            state_nxt = IDLE;
         CLEAR:
`ifdef CELL_WRITER_CLEAR_ALL_EN
            if (bus.mem_grant_in && addr_q == LAST_ADDR) state_nxt = DONE;
`else
            state_nxt = DONE;
`endif
         default:
            state_nxt = IDLE;
      endcase
   end

   // outputs; write enable is gated by grant combinationally so it can never
   // be seen while another master owns the port
   always_comb begin
      bus.cmd_ready_out = (state == IDLE);
      bus.busy_out      = (state != IDLE);
      bus.done_out      = (state == DONE);
      bus.we_out        = 1'b0;
      if (bus.mem_grant_in) begin
         if (state == WRITE) bus.we_out = 1'b1;
`ifdef CELL_WRITER_CLEAR_ALL_EN
         if (state == CLEAR) bus.we_out = 1'b1;
`endif
      end
      bus.addr_out   = addr_q;
      bus.data_w_out = wdata_q;
   end

   // command latch, read counter, address and write data
   always_ff @(posedge clk_130mhz or posedge rst_in) begin
      if (rst_in) begin
         x_q     <= '0;
         y_q     <= '0;
         op_q    <= OP_SET;
         rd_cnt  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (accept) begin
            x_q  <= bus.cmd_x_in;
            y_q  <= bus.cmd_y_in;
            op_q <= bus.cmd_op_in;
            if (bus.cmd_op_in == OP_CLEAR_ALL) begin
               addr_q  <= '0;
               wdata_q <= '0;
            end
         end
         case (state)
            WAIT_GRANT: begin
               rd_cnt <= '0;
               addr_q <= map_addr;
            end
            READ:
               if (!bus.mem_grant_in)     rd_cnt  <= '0;
               else if (rd_cnt == RD_LAST) wdata_q <= word_mod;
               else                        rd_cnt  <= rd_cnt + 3'd1;
`ifdef CELL_WRITER_CLEAR_ALL_EN
            CLEAR:
               if (bus.mem_grant_in) addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
